axi_mm2s_dma: RTL

AXI_MM2S_DMA -- requirements
Module: axi_mm2s_dma

---
 rtl/axi_mm2s_dma_if.sv | 47 ++++
 rtl/axi_mm2s_dma.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/axi_mm2s_dma_if.sv
// AXI3 read-address/read-data channels plus the outgoing stream, as seen by the MM2S DMA.
// Every channel transfers a beat on a rising clock edge where valid && ready; the source keeps
// valid and its payload stable until that edge, and ready may be driven combinationally.
interface axi_mm2s_dma_if #(
    parameter int DATA_W = 64
);
    logic [2:0]        m_axi_acp_arid;
    logic [31:0]       m_axi_acp_araddr;
    logic [3:0]        m_axi_acp_arlen;
    logic [2:0]        m_axi_acp_arsize;
    logic [1:0]        m_axi_acp_arburst;
    logic [3:0]        m_axi_acp_arcache;
    logic [2:0]        m_axi_acp_arprot;
    logic              m_axi_acp_arvalid;
    logic              m_axi_acp_arready;

    logic [DATA_W-1:0] m_axi_acp_rdata;
    logic [1:0]        m_axi_acp_rresp;
    logic              m_axi_acp_rlast;
    logic              m_axi_acp_rvalid;
    logic              m_axi_acp_rready;

    logic [DATA_W-1:0] mm2s_data;
    logic              mm2s_valid;
    logic              mm2s_last;
    logic              mm2s_ready;

    modport master (
        output m_axi_acp_arid, m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arsize,
               m_axi_acp_arburst, m_axi_acp_arcache, m_axi_acp_arprot, m_axi_acp_arvalid,
        input  m_axi_acp_arready,
        input  m_axi_acp_rdata, m_axi_acp_rresp, m_axi_acp_rlast, m_axi_acp_rvalid,
        output m_axi_acp_rready,
        output mm2s_data, mm2s_valid, mm2s_last,
        input  mm2s_ready
    );

    modport slave (
        input  m_axi_acp_arid, m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arsize,
               m_axi_acp_arburst, m_axi_acp_arcache, m_axi_acp_arprot, m_axi_acp_arvalid,
        output m_axi_acp_arready,
        output m_axi_acp_rdata, m_axi_acp_rresp, m_axi_acp_rlast, m_axi_acp_rvalid,
        input  m_axi_acp_rready,
        input  mm2s_data, mm2s_valid, mm2s_last,
        output mm2s_ready
    );
endinterface

// File: rtl/axi_mm2s_dma.sv
// Memory-to-stream DMA: issues AXI3 INCR read bursts (4 KB safe, bounded outstanding)
// and forwards read data straight onto the stream with a whole-transfer last flag.
module axi_mm2s_dma #(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUT   = 4,
    parameter int LEN_W     = 24
) (
    input  logic              m_axi_acp_aclk,
    input  logic              axi_resetn,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [LEN_W-1:0]  num_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state,
    axi_mm2s_dma_if.master    axi
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       ar_addr;
    logic [3:0]        ar_len;
    logic [4:0]        ar_beats;
    logic              ar_valid;
    logic [LEN_W-1:0]  rem_ar;
    logic [LEN_W-1:0]  last_idx;
    logic [LEN_W-1:0]  r_cnt;
    logic [3:0]        outstanding;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              active;
    logic              ar_hs;
    logic              r_hs;
    logic              final_beat;
    logic [12:0]       to_4k_bytes;
    logic [12:0]       to_4k_beats;
    logic [4:0]        rem_clip;
    logic [4:0]        b4k_clip;
    logic [4:0]        next_beats;

    assign active     = (state != IDLE);
    assign ar_hs      = ar_valid && axi.m_axi_acp_arready;
    assign r_hs       = axi.m_axi_acp_rvalid && axi.mm2s_ready;
    assign final_beat = active && (r_cnt == last_idx);

    // Burst size is the smallest of the burst cap, the remaining work and the room left in this 4 KB page.
    always_comb begin
        to_4k_bytes = 13'h1000 - {1'b0, ar_addr[11:0]};
        to_4k_beats = to_4k_bytes >> SZ;
        rem_clip    = (rem_ar >= LEN_W'(MAX_BURST)) ? 5'(MAX_BURST) : rem_ar[4:0];
        b4k_clip    = (to_4k_beats >= 13'(MAX_BURST)) ? 5'(MAX_BURST) : to_4k_beats[4:0];
        next_beats  = (rem_clip < b4k_clip) ? rem_clip : b4k_clip;
    end

    assign axi.m_axi_acp_arid    = 3'b100;
    assign axi.m_axi_acp_araddr  = ar_addr;
    assign axi.m_axi_acp_arlen   = ar_len;
    assign axi.m_axi_acp_arsize  = 3'(SZ);
    assign axi.m_axi_acp_arburst = 2'b01;
    assign axi.m_axi_acp_arcache = 4'b0011;
    assign axi.m_axi_acp_arprot  = 3'b010;
    assign axi.m_axi_acp_arvalid = ar_valid;

    // Read data is a pure wire-through; the stream sink owns the R channel back-pressure.
    assign axi.m_axi_acp_rready = axi.mm2s_ready;
    assign axi.mm2s_valid       = axi.m_axi_acp_rvalid;
    assign axi.mm2s_data        = axi.m_axi_acp_rdata;
    assign axi.mm2s_last        = final_beat;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state;

    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state       <= IDLE;
            ar_addr     <= '0;
            ar_len      <= '0;
            ar_beats    <= '0;
            ar_valid    <= 1'b0;
            rem_ar      <= '0;
            last_idx    <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end

            // Bursts still count as outstanding only for the transfer in flight, never for stray beats.
            case ({ar_hs, active && r_hs && axi.m_axi_acp_rlast})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            if (active && r_hs) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (axi.m_axi_acp_rresp != 2'b00) begin
                    err_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start && !busy_q) begin
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        ar_addr  <= base_addr & ~32'(BYTES - 1);
                        rem_ar   <= num_beats;
                        last_idx <= num_beats - LEN_W'(1);
                        r_cnt    <= '0;
                        if (num_beats == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ar_hs) begin
                        ar_valid <= 1'b0;
                        ar_addr  <= ar_addr + (32'(ar_beats) << SZ);
                        rem_ar   <= rem_ar - LEN_W'(ar_beats);
                        if (rem_ar == LEN_W'(ar_beats)) begin
                            state <= DRAIN;
                        end
                    end else if (!ar_valid && (rem_ar != '0) && (outstanding < 4'(MAX_OUT))) begin
                        ar_valid <= 1'b1;
                        ar_len   <= 4'(next_beats - 5'd1);
                        ar_beats <= next_beats;
                    end
                end
                DRAIN: begin
                    state <= DRAIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The final beat also retires the last outstanding burst, so this is the DRAIN exit.
            if (active && r_hs && final_beat) begin
                state  <= IDLE;
                done_q <= 1'b1;
            end
        end
    end
endmodule
